gpio_pad_arbiter: RTL and testbench

Shares the 32-bit gpioA pad bank between two output masters: requester 0 is the e203 SoC GPIO controller and requester 1 is a hardware sampler engine. The block sits between the masters and the gpioA IOBUF array in the FPGA top. It grants ownership with a req/gnt handshake and tristates the bank for a turnaround gap between owners. It enforces a maximum hold time with preemption and feeds registered oval/oe to the IOBUFs.

---
 rtl/gpio_pad_arbiter_pkg.sv | 19 +
 rtl/gpio_pad_arbiter_outreg.sv | 33 +++
 rtl/gpio_pad_arbiter.sv | 111 +++++++++++
 tb/tb_gpio_pad_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pad_arbiter_pkg.sv
// Shared types and widths for the gpioA pad-bank arbiter: FSM state encoding
// and counter widths.
package gpio_pad_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_TURN = 2'd3
  } arb_state_t;

  localparam int HOLD_W = 16;
  localparam int TURN_W = 4;

  function automatic logic is_own(input arb_state_t s);
    return (s == ST_OWN0) || (s == ST_OWN1);
  endfunction

endpackage

// File: rtl/gpio_pad_arbiter_outreg.sv
// Registered 2:1 output stage feeding the gpioA IOBUF array. force_zero
// overrides the select so the bank is tristated and driven low.
module gpio_pad_outreg #(
  parameter int WIDTH = 32
) (
  input  logic             clk_16M,
  input  logic             reset_periph,
  input  logic             sel,
  input  logic             force_zero,
  input  logic [WIDTH-1:0] m0_oval,
  input  logic [WIDTH-1:0] m0_oe,
  input  logic [WIDTH-1:0] m1_oval,
  input  logic [WIDTH-1:0] m1_oe,
  output logic [WIDTH-1:0] pad_oval,
  output logic [WIDTH-1:0] pad_oe
);

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_16M) begin
    if (reset_periph || force_zero) begin
      pad_oval <= '0;
      pad_oe   <= '0;
    end else if (sel) begin
      pad_oval <= m1_oval;
      pad_oe   <= m1_oe;
    end else begin
      pad_oval <= m0_oval;
      pad_oe   <= m0_oe;
    end
  end

endmodule

// File: rtl/gpio_pad_arbiter.sv
// Two-master arbiter for the gpioA pad bank: round-robin grant, tristate
// turnaround between owners, MAX_HOLD preemption, registered pad outputs.
module gpio_pad_arbiter
  import gpio_pad_arbiter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int TURN_CYCLES = 2,
  parameter int MAX_HOLD    = 1024
) (
  input  logic             clk_16M,
  input  logic             reset_periph,
  input  logic [1:0]       req,
  output logic [1:0]       gnt,
  input  logic [WIDTH-1:0] m0_oval,
  input  logic [WIDTH-1:0] m0_oe,
  input  logic [WIDTH-1:0] m1_oval,
  input  logic [WIDTH-1:0] m1_oe,
  output logic [WIDTH-1:0] pad_oval,
  output logic [WIDTH-1:0] pad_oe,
  output logic             owner_valid,
  output logic             owner_id,
  output logic             preempt
);

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYCLES - 1);

  arb_state_t        state, next_state;
  logic              last;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TURN_W-1:0] turn_cnt;

  logic own_now, own_id, req_own, req_other, hold_expired, stay_owned;

  assign own_now      = is_own(state);
  assign own_id       = (state == ST_OWN1);
  assign req_own      = own_id ? req[1] : req[0];
  assign req_other    = own_id ? req[0] : req[1];
  assign hold_expired = (MAX_HOLD != 0) && req_other && (hold_cnt == HOLD_LAST);
  assign stay_owned   = own_now && (next_state == state);

  // NOTE: every always_comb output gets a default first so no path through
  // the case leaves it unassigned and infers a latch.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        case (req)
          2'b01:   next_state = ST_OWN0;
          2'b10:   next_state = ST_OWN1;
          2'b11:   next_state = last ? ST_OWN0 : ST_OWN1;
          default: next_state = ST_IDLE;
        endcase
      end
      ST_OWN0, ST_OWN1: begin
        if (!req_own || hold_expired) next_state = ST_TURN;
      end
      ST_TURN: begin
        if (turn_cnt == TURN_LAST) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_16M) begin
    if (reset_periph) begin
      state       <= ST_IDLE;
      last        <= 1'b1;
      hold_cnt    <= '0;
      turn_cnt    <= '0;
      gnt         <= 2'b00;
      owner_valid <= 1'b0;
      owner_id    <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      state       <= next_state;
      gnt         <= {next_state == ST_OWN1, next_state == ST_OWN0};
      owner_valid <= is_own(next_state);
      owner_id    <= (next_state == ST_OWN1);
      // A simultaneous release wins over preemption: only flag it while req is still held.
      preempt     <= own_now && req_own && hold_expired;

      if (stay_owned) begin
        if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end

      if (own_now && next_state == ST_TURN) last <= own_id;

      if (state == ST_TURN && next_state == ST_TURN) turn_cnt <= turn_cnt + 1'b1;
      else turn_cnt <= '0;
    end
  end

  // Pads only carry master data while ownership continues across the edge.
  gpio_pad_outreg #(.WIDTH(WIDTH)) u_outreg (
    .clk_16M      (clk_16M),
    .reset_periph (reset_periph),
    .sel          (own_id),
    .force_zero   (!stay_owned),
    .m0_oval      (m0_oval),
    .m0_oe        (m0_oe),
    .m1_oval      (m1_oval),
    .m1_oe        (m1_oe),
    .pad_oval     (pad_oval),
    .pad_oe       (pad_oe)
  );

endmodule

// File: tb/tb_gpio_pad_arbiter.sv
// Self-checking bench for gpio_pad_arbiter: directed scenarios plus random
// req traffic, compared against a cycle-level ownership model.
module tb_gpio_pad_arbiter;

  localparam int W  = 32;
  localparam int T  = 2;
  localparam int MA = 8;

  logic          clk = 1'b0;
  logic          reset_periph = 1'b1;
  logic [1:0]    req = 2'b00;
  logic [W-1:0]  m0_oval = '0, m0_oe = '0, m1_oval = '0, m1_oe = '0;

  logic [1:0]    gnt_a, gnt_b;
  logic [W-1:0]  pad_oval_a, pad_oe_a, pad_oval_b, pad_oe_b;
  logic          owner_valid_a, owner_id_a, preempt_a;
  logic          owner_valid_b, owner_id_b, preempt_b;

  always #5 clk = ~clk;

  gpio_pad_arbiter #(.WIDTH(W), .TURN_CYCLES(T), .MAX_HOLD(MA)) dut_a (
    .clk_16M(clk), .reset_periph(reset_periph), .req(req), .gnt(gnt_a),
    .m0_oval(m0_oval), .m0_oe(m0_oe), .m1_oval(m1_oval), .m1_oe(m1_oe),
    .pad_oval(pad_oval_a), .pad_oe(pad_oe_a),
    .owner_valid(owner_valid_a), .owner_id(owner_id_a), .preempt(preempt_a)
  );

  gpio_pad_arbiter #(.WIDTH(W), .TURN_CYCLES(T), .MAX_HOLD(0)) dut_b (
    .clk_16M(clk), .reset_periph(reset_periph), .req(req), .gnt(gnt_b),
    .m0_oval(m0_oval), .m0_oe(m0_oe), .m1_oval(m1_oval), .m1_oe(m1_oe),
    .pad_oval(pad_oval_b), .pad_oe(pad_oe_b),
    .owner_valid(owner_valid_b), .owner_id(owner_id_b), .preempt(preempt_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ownership model for dut_a: owner (-1 = none), cycles owned so far,
  // position in the release gap (1..T = tristate, 0 = idle/arbitrating).
  int           mo = -1;
  int           m_since = 0;
  int           m_gap = 0;
  int           m_last = 1;
  logic         m_pre = 1'b0;
  logic [W-1:0] e_oe = '0, e_oval = '0;

  task automatic model_step();
    int prev;
    prev  = mo;
    m_pre = 1'b0;
    if (reset_periph) begin
      mo = -1; m_since = 0; m_gap = 0; m_last = 1;
      e_oe = '0; e_oval = '0;
      return;
    end
    if (mo >= 0) begin
      if (!req[mo]) begin
        m_last = mo; mo = -1; m_gap = 1;
      end else if (MA != 0 && req[1-mo] && m_since == MA) begin
        m_pre = 1'b1; m_last = mo; mo = -1; m_gap = 1;
      end else begin
        m_since++;
      end
    end else if (m_gap > 0) begin
      m_gap = (m_gap == T) ? 0 : m_gap + 1;
    end else if (req != 2'b00) begin
      mo      = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
      m_since = 1;
    end
    if (prev >= 0 && mo == prev) begin
      e_oe   = (prev == 1) ? m1_oe   : m0_oe;
      e_oval = (prev == 1) ? m1_oval : m0_oval;
    end else begin
      e_oe = '0; e_oval = '0;
    end
  endtask

  int   zero_run = 0;
  logic seen_grant = 1'b0;

  task automatic tick();
    logic [1:0] eg;
    @(posedge clk);
    model_step();
    #1;
    eg = (mo < 0) ? 2'b00 : ((mo == 1) ? 2'b10 : 2'b01);
    check("gnt", 32'(gnt_a), 32'(eg));
    check("owner_valid", 32'(owner_valid_a), 32'(mo >= 0));
    check("owner_id", 32'(owner_id_a), 32'(mo == 1));
    check("preempt", 32'(preempt_a), 32'(m_pre));
    check("pad_oe", pad_oe_a, e_oe);
    check("pad_oval", pad_oval_a, e_oval);
    check("gnt_onehot", 32'(gnt_a != 2'b11), 32'd1);
    if (!owner_valid_a) check("idle_tristate", pad_oe_a, 32'd0);
    if (reset_periph) begin
      seen_grant = 1'b0; zero_run = 0;
    end else if (gnt_a == 2'b00) begin
      zero_run++;
    end else begin
      if (seen_grant && zero_run > 0) check("turn_gap", 32'(zero_run >= T + 1), 32'd1);
      seen_grant = 1'b1; zero_run = 0;
    end
  endtask

  task automatic do_reset();
    reset_periph = 1'b1;
    tick();
    reset_periph = 1'b0;
  endtask

  initial begin
    int cnt, pcount, waitc;

    // Reset state
    tick();
    tick();
    check("rst_gnt", 32'(gnt_a), 32'd0);
    check("rst_pad_oe", pad_oe_a, 32'd0);
    check("rst_pad_oval", pad_oval_a, 32'd0);
    check("rst_owner_valid", 32'(owner_valid_a), 32'd0);
    check("rst_preempt", 32'(preempt_a), 32'd0);
    reset_periph = 1'b0;

    // Single requester: grant after one edge, pads one edge later
    req = 2'b01; m0_oe = 32'hFFFF_FFFF; m0_oval = 32'hA5A5_A5A5;
    tick();
    check("t1_gnt", 32'(gnt_a), 32'h1);
    check("t1_owner_id", 32'(owner_id_a), 32'h0);
    check("t1_pad_not_yet", pad_oe_a, 32'h0);
    tick();
    check("t1_pad_oe", pad_oe_a, 32'hFFFF_FFFF);
    check("t1_pad_oval", pad_oval_a, 32'hA5A5_A5A5);
    req = 2'b00;
    tick();
    check("t1_release_gnt", 32'(gnt_a), 32'h0);
    check("t1_release_pad", pad_oe_a, 32'h0);
    repeat (3) tick();

    // Both request together after reset; release of master 0 hands over
    do_reset();
    req = 2'b11; m1_oe = 32'h0F0F_0F0F; m1_oval = 32'h1234_5678;
    tick();
    check("t2_first_gnt", 32'(gnt_a), 32'h1);
    tick();
    req = 2'b10;
    tick();
    check("t2_drop_gnt", 32'(gnt_a), 32'h0);
    check("t2_drop_pad", pad_oe_a, 32'h0);
    tick();
    check("t2_turn2_gnt", 32'(gnt_a), 32'h0);
    tick();
    check("t2_idle_gnt", 32'(gnt_a), 32'h0);
    tick();
    check("t2_handover_gnt", 32'(gnt_a), 32'h2);
    tick();
    check("t2_m1_pad_oe", pad_oe_a, 32'h0F0F_0F0F);
    req = 2'b00;
    repeat (4) tick();

    // Preemption with MAX_HOLD=8
    do_reset();
    req = 2'b01;
    tick();
    req = 2'b11;
    cnt = 1; pcount = 0; waitc = 0;
    while (gnt_a[0] && waitc < 50) begin
      tick();
      waitc++;
      if (gnt_a[0]) cnt++;
      if (preempt_a) pcount++;
    end
    check("t3_hold_cycles", 32'(cnt), 32'(MA));
    check("t3_preempt_at_drop", 32'(preempt_a), 32'h1);
    waitc = 0;
    while (gnt_a != 2'b10 && waitc < 50) begin
      tick();
      waitc++;
      if (preempt_a) pcount++;
    end
    check("t3_handover_delay", 32'(waitc), 32'(T + 1));
    check("t3_preempt_pulses", 32'(pcount), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_no_regrant", 32'(gnt_a[0]), 32'h0);
    end
    req = 2'b01;
    tick();
    check("t3_m1_release", 32'(gnt_a), 32'h0);
    waitc = 0;
    while (gnt_a != 2'b01 && waitc < 50) begin
      tick();
      waitc++;
    end
    check("t3_regrant_delay", 32'(waitc), 32'(T + 1));
    req = 2'b00;
    repeat (4) tick();

    // MAX_HOLD=0 instance: both held for 5000 cycles, no preemption
    do_reset();
    m0_oe = 32'h0000_FFFF; m0_oval = 32'h0000_C3C3;
    req = 2'b11;
    tick();
    check("t4_first_owner", 32'(gnt_b), 32'h1);
    pcount = 0; cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (preempt_b) pcount++;
      if (gnt_b != 2'b01 || owner_id_b != 1'b0 || !owner_valid_b) cnt++;
      if (pad_oe_b != 32'h0000_FFFF || pad_oval_b != 32'h0000_C3C3) cnt++;
    end
    check("t4_preempt_count", 32'(pcount), 32'h0);
    check("t4_owner_changes", 32'(cnt), 32'h0);

    // Reset during OWN1 with pads driven
    do_reset();
    req = 2'b10; m1_oe = 32'h0000_00FF; m1_oval = 32'h0000_005A;
    tick();
    tick();
    check("t5_pad_oe", pad_oe_a, 32'h0000_00FF);
    check("t5_owner_id", 32'(owner_id_a), 32'h1);
    reset_periph = 1'b1;
    tick();
    check("t5_rst_gnt", 32'(gnt_a), 32'h0);
    check("t5_rst_pad", pad_oe_a, 32'h0);
    check("t5_rst_valid", 32'(owner_valid_a), 32'h0);
    reset_periph = 1'b0;
    req = 2'b11;
    tick();
    check("t5_m0_wins", 32'(gnt_a), 32'h1);
    check("t5_m0_wins_b", 32'(gnt_b), 32'h1);

    // Random req toggling with occasional reset
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) req[0] = ~req[0];
      if ($urandom_range(7) == 0) req[1] = ~req[1];
      m0_oval = $urandom; m0_oe = $urandom;
      m1_oval = $urandom; m1_oe = $urandom;
      reset_periph = ($urandom_range(499) == 0);
      tick();
    end
    reset_periph = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
